// File: rtl/mem_responder.sv
// Fixed-latency word-organised 16-bit memory responder, one request at a time.
// Optional MEM_RESPONDER_ERR_EN adds a mem_err protocol-violation pulse.
module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_byte_enable,
    input  logic [15:0]           mem_address,
    input  logic [15:0]           mem_wdata,
    output logic                  mem_resp,
`ifdef MEM_RESPONDER_ERR_EN
    output logic                  mem_err,
`endif
    output logic [15:0]           mem_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [1:0]              be_q, be_d;
    logic                    wr_q, wr_d;
    logic [15:0]             rdata_q, rdata_d;
    logic                    enter_resp;

    logic [15:0]             mem_q [DEPTH];

    logic                    in_idle;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic [15:0]             cur_wdata;
    logic [1:0]              cur_be;
    logic                    cur_wr;
    logic [15:0]             rd_word;
    logic [15:0]             merged;
    logic                    unused_addr;

    assign unused_addr = ^mem_address;

    // With LATENCY=1 the commit happens on the accepting edge, so use live inputs
    assign in_idle   = (state_q == IDLE);
    assign cur_idx   = in_idle ? mem_address[ADDR_WIDTH:1] : idx_q;
    assign cur_wdata = in_idle ? mem_wdata : wdata_q;
    assign cur_be    = in_idle ? mem_byte_enable : be_q;
    assign cur_wr    = in_idle ? mem_write : wr_q;
    assign rd_word   = mem_q[cur_idx];
    assign merged    = {cur_be[1] ? cur_wdata[15:8] : rd_word[15:8],
                        cur_be[0] ? cur_wdata[7:0]  : rd_word[7:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    idx_d   = mem_address[ADDR_WIDTH:1];
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    wr_d    = mem_write;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        cnt_d      = 4'd0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdata_d = rdata_q;
        if (enter_resp) begin
            rdata_d = cur_wr ? merged : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            wr_q    <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Store is never cleared; reset only blocks a pending commit
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_wr) begin
            mem_q[cur_idx] <= merged;
        end
    end

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;

`ifdef MEM_RESPONDER_ERR_EN
    logic [15:0] addr_q, addr_d;
    logic        err_q, err_d;

    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    addr_d = mem_address;
                    err_d  = mem_read & mem_write;
                end
            end
            WAIT: begin
                if (!(mem_read | mem_write) || (mem_address != addr_q)) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign mem_err = (state_q == RESP) & err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus random traffic
// checked against a word-array reference model.
module tb_mem_responder;

    localparam int AW      = 8;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
`ifdef MEM_RESPONDER_ERR_EN
    logic        mem_err;
`endif

    int checks = 0;
    int fails  = 0;

    logic [15:0] model [DEPTH];

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LATENCY)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
`ifdef MEM_RESPONDER_ERR_EN
        .mem_err        (mem_err),
`endif
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    // One complete transaction; model updated from the values at acceptance
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input bit drop, input bit chg);
        int n;
        bit got;
        int i;
        logic [15:0] word;
        logic [15:0] exp_rdata;
        bit exp_err;
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        @(posedge clk);
        i    = widx(addr);
        word = model[i];
        if (wr) begin
            if (be[0]) word = (word & 16'hFF00) | (wdata & 16'h00FF);
            if (be[1]) word = (word & 16'h00FF) | (wdata & 16'hFF00);
            model[i] = word;
        end
        exp_rdata = word;
        exp_err   = (rd && wr) || (LATENCY > 1 && (drop || chg));
        n   = 0;
        got = 0;
        while (n < LATENCY + 3 && !got) begin
            @(negedge clk);
            n++;
            if (mem_resp) begin
                got = 1;
            end else begin
                if (drop) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
                if (chg) mem_address = addr ^ 16'h0002;
                mem_wdata       = 16'($urandom);
                mem_byte_enable = 2'($urandom);
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", n, LATENCY);
            chk("rdata", 32'(mem_rdata), 32'(exp_rdata));
`ifdef MEM_RESPONDER_ERR_EN
            chk("err", 32'(mem_err), 32'(exp_err));
`endif
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", 32'(mem_resp), 32'd0);
    endtask

    initial begin
        logic [15:0] old_word;
        int op;
        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        mem_byte_enable = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", 32'(mem_resp), 32'd0);
        chk("reset_rdata", 32'(mem_rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_resp", 32'(mem_resp), 32'd0);

        for (int k = 0; k < DEPTH; k++) begin
            do_req(0, 1, 16'(k * 2), 16'($urandom), 2'b11, 0, 0);
        end

        do_req(0, 1, 16'h0010, 16'hBEEF, 2'b11, 0, 0);
        do_req(1, 0, 16'h0010, 16'h0000, 2'b00, 0, 0);
        chk("beef", 32'(mem_rdata), 32'h0000BEEF);
        do_req(0, 1, 16'h0010, 16'h1234, 2'b01, 0, 0);
        do_req(1, 0, 16'h0010, 16'h0000, 2'b11, 0, 0);
        chk("mask01", 32'(mem_rdata), 32'h0000BE34);
        do_req(0, 1, 16'h0010, 16'hAA00, 2'b10, 0, 0);
        do_req(1, 0, 16'h0010, 16'h0000, 2'b00, 0, 0);
        chk("mask10", 32'(mem_rdata), 32'h0000AA34);
        do_req(0, 1, 16'h0010, 16'h5555, 2'b00, 0, 0);
        do_req(1, 0, 16'h0011, 16'h0000, 2'b00, 0, 0);
        chk("odd_byte_mask00", 32'(mem_rdata), 32'h0000AA34);
        do_req(1, 0, 16'h0210, 16'h0000, 2'b00, 0, 0);
        chk("alias", 32'(mem_rdata), 32'h0000AA34);
        do_req(1, 1, 16'h0020, 16'hC0DE, 2'b11, 0, 0);
        do_req(1, 0, 16'h0020, 16'h0000, 2'b00, 0, 0);
        chk("rw_is_write", 32'(mem_rdata), 32'h0000C0DE);

        // Continuous read: pulse every LATENCY+1 cycles, never back-to-back
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 16'h0020;
        for (int i = 1; i <= 5 * (LATENCY + 1); i++) begin
            @(negedge clk);
            chk("hold_resp", 32'(mem_resp),
                32'((i % (LATENCY + 1)) == LATENCY));
            if (mem_resp) chk("hold_rdata", 32'(mem_rdata), 32'h0000C0DE);
        end
        mem_read = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        chk("hold_quiet", 32'(mem_resp), 32'd0);

        // Reset during WAIT aborts a write
        old_word        = model[widx(16'h0030)];
        mem_write       = 1'b1;
        mem_address     = 16'h0030;
        mem_wdata       = ~old_word;
        mem_byte_enable = 2'b11;
        @(posedge clk);
        for (int i = 0; i < LATENCY - 1; i++) @(negedge clk);
        rst_n     = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_resp", 32'(mem_resp), 32'd0);
        chk("abort_rdata", 32'(mem_rdata), 32'd0);
        rst_n = 1'b1;
        repeat (LATENCY + 1) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(mem_resp), 32'd0);
        end
        do_req(1, 0, 16'h0030, 16'h0000, 2'b00, 0, 0);
        chk("abort_old", 32'(mem_rdata), 32'(old_word));

        for (int k = 0; k < 300; k++) begin
            op = int'($urandom_range(0, 2));
            do_req(op != 1, op != 0, 16'($urandom), 16'($urandom),
                   2'($urandom), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
